// File: rtl/sangdich_ctrl.sv
// LED-chaser sequencer: prescaled step tick plus load/step/dir/fill controls for one shifter.
// load/step are combinational from registered state and current inputs; run=0 pauses, holding the prescaler.
module sangdich_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     rs,
  input  logic                     run,
  input  logic [1:0]               mode,
  input  logic [DIV_W-1:0]         div,
  output logic                     load,
  output logic [WIDTH-1:0]         load_pat,
  output logic                     step,
  output logic                     dir,
  output logic                     fill_bit,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     busy
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0] PMAX = PW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] PAUSE = 2'd3;

  localparam logic [1:0] M_ROTL   = 2'd0;
  localparam logic [1:0] M_ROTR   = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_FILL   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] cnt;
  logic             phase;
  logic             mchg;
  logic             tc;
  logic [PW-1:0]    pos_nxt;
  logic             dir_nxt;
  logic             phase_nxt;

  assign mchg = (mode != mode_q);
  // >= rather than == so a div lowered below the running count fires at once
  assign tc   = (cnt >= div);
  assign load = (state == LOAD);
  assign step = (state == RUN) && !mchg && run && tc;
  assign busy = (state != IDLE);

  always_comb begin
    load_pat = '0;
    if (load) begin
      case (mode)
        M_ROTR:  load_pat = {1'b1, {(WIDTH-1){1'b0}}};
        M_FILL:  load_pat = '0;
        default: load_pat = WIDTH'(1);
      endcase
    end
  end

  always_comb begin
    fill_bit = 1'b0;
    if (step) begin
      case (mode_q)
        M_ROTL:  fill_bit = (pos == PMAX);
        M_ROTR:  fill_bit = (pos == '0);
        M_FILL:  fill_bit = ~phase;
        default: fill_bit = 1'b0;
      endcase
    end
  end

  always_comb begin
    pos_nxt   = pos;
    dir_nxt   = dir;
    phase_nxt = phase;
    case (mode_q)
      M_ROTL: pos_nxt = pos + PW'(1);
      M_ROTR: pos_nxt = pos - PW'(1);
      M_BOUNCE: begin
        pos_nxt = dir ? (pos - PW'(1)) : (pos + PW'(1));
        // turn around on the edge that lands on an end LED
        if (pos_nxt == PMAX) begin
          dir_nxt = 1'b1;
        end else if (pos_nxt == '0) begin
          dir_nxt = 1'b0;
        end
      end
      default: begin
        pos_nxt = (pos == PMAX) ? '0 : (pos + PW'(1));
        if (pos == PMAX) begin
          phase_nxt = ~phase;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state  <= IDLE;
      mode_q <= 2'd0;
      cnt    <= '0;
      phase  <= 1'b0;
      pos    <= '0;
      dir    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          state  <= RUN;
          mode_q <= mode;
          cnt    <= '0;
          phase  <= 1'b0;
          if (mode == M_ROTR) begin
            pos <= PMAX;
            dir <= 1'b1;
          end else begin
            pos <= '0;
            dir <= 1'b0;
          end
        end
        RUN: begin
          if (mchg) begin
            state <= LOAD;
          end else if (!run) begin
            state <= PAUSE;
          end else if (tc) begin
            cnt   <= '0;
            pos   <= pos_nxt;
            dir   <= dir_nxt;
            phase <= phase_nxt;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: begin
          if (run) begin
            state <= mchg ? LOAD : RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sangdich_ctrl.sv
// Bench for sangdich_ctrl: directed phases feed an expected-event queue; a negedge monitor
// drives a model shifter from the DUT controls and checks each load/step against the queue.
module tb_sangdich_ctrl;

  localparam int W  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rs  = 1'b1;
  logic          run = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] div = '0;
  logic          load;
  logic [W-1:0]  load_pat;
  logic          step;
  logic          dir;
  logic          fill_bit;
  logic [2:0]    pos;
  logic          busy;

  sangdich_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk(clk), .rs(rs), .run(run), .mode(mode), .div(div),
    .load(load), .load_pat(load_pat), .step(step), .dir(dir),
    .fill_bit(fill_bit), .pos(pos), .busy(busy)
  );

  always #5 clk = ~clk;

  // kind 1 = load, 2 = step; gap 0 = interval not checked
  typedef struct {
    int         kind;
    int         gap;
    logic [7:0] led;
  } ev_t;

  ev_t        q[$];
  ev_t        mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         ncyc    = 0;
  int         last_ev = 0;
  logic [7:0] led_m   = 8'h00;

  logic [7:0] t_rotl   [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] t_rotr   [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
  logic [7:0] t_bounce [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] t_fill   [17] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int gap, input logic [7:0] led);
    ev_t e;
    e.kind = kind;
    e.gap  = gap;
    e.led  = led;
    q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    do begin
      @(posedge clk);
      i++;
    end while (q.size() != 0 && i < budget);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d events still expected after %0d cycles, required 0", name, q.size(), budget);
      q.delete();
    end
  endtask

  task automatic end_phase(input string name);
    wait_drain(name, 400);
    #1;
    rs  = 1'b0;
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rs = 1'b1;
  endtask

  // Monitor: the model shifter consumes exactly the controls a real shifter would see
  always @(negedge clk) begin
    ncyc++;
    if (!rs) begin
      led_m = 8'h00;
    end else if (load || step) begin
      chk("load_step_exclusive", int'(load && step), 0);
      led_m = load ? load_pat : (dir ? {fill_bit, led_m[7:1]} : {led_m[6:0], fill_bit});
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got load=%0b step=%0b led=0x%0h at cycle %0d, required no event",
                 load, step, led_m, ncyc);
      end else begin
        mon_e = q.pop_front();
        chk("event_kind", load ? 1 : 2, mon_e.kind);
        if (mon_e.gap > 0) chk("event_gap", ncyc - last_ev, mon_e.gap);
        chk("led", int'(led_m), int'(mon_e.led));
      end
      last_ev = ncyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #1 rs = 1'b0;
    #1;
    chk("rst_load", int'(load), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pos", int'(pos), 0);
    chk("rst_load_pat", int'(load_pat), 0);
    @(posedge clk);
    #1;

    // rotate-left, div=3: step every 4 cycles after the load
    rs = 1'b1; mode = 2'd0; div = 16'd3; run = 1'b1;
    push(1, 0, 8'h01);
    foreach (t_rotl[i]) push(2, 4, t_rotl[i]);
    end_phase("rotl");

    // rotate-right, div=1, then async reset mid-cycle
    mode = 2'd1; div = 16'd1; run = 1'b1;
    push(1, 0, 8'h80);
    foreach (t_rotr[i]) push(2, 2, t_rotr[i]);
    wait_drain("rotr", 400);
    chk("pre_rst_dir", int'(dir), 1);
    #3 rs = 1'b0;
    #1;
    chk("async_load", int'(load), 0);
    chk("async_load_pat", int'(load_pat), 0);
    chk("async_step", int'(step), 0);
    chk("async_dir", int'(dir), 0);
    chk("async_fill_bit", int'(fill_bit), 0);
    chk("async_pos", int'(pos), 0);
    chk("async_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rs = 1'b1; run = 1'b0; mode = 2'd0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_load_step_busy", int'({load, step, busy}), 0);
    end
    @(posedge clk);
    #1;

    // bounce, div=0: step every cycle
    mode = 2'd2; div = 16'd0; run = 1'b1;
    push(1, 0, 8'h01);
    foreach (t_bounce[i]) push(2, 1, t_bounce[i]);
    end_phase("bounce");

    // fill/empty, div=1
    mode = 2'd3; div = 16'd1; run = 1'b1;
    push(1, 0, 8'h00);
    foreach (t_fill[i]) push(2, 2, t_fill[i]);
    end_phase("fill");

    // pause mid-count, then mode change on the terminal-count cycle
    mode = 2'd0; div = 16'd4; run = 1'b1;
    push(1, 0, 8'h01);
    push(2, 5, 8'h02);
    push(2, 16, 8'h04);
    push(1, 6, 8'h80);
    push(2, 5, 8'h40);
    repeat (9) @(posedge clk);
    #1 run = 1'b0;
    repeat (10) @(posedge clk);
    #1 run = 1'b1;
    repeat (8) @(posedge clk);
    #1 mode = 2'd1;
    end_phase("pause_mchg");

    // div lowered 100 -> 2 at the edge where cnt leaves 50
    mode = 2'd0; div = 16'd100; run = 1'b1;
    push(1, 0, 8'h01);
    push(2, 52, 8'h02);
    push(2, 3, 8'h04);
    push(2, 3, 8'h08);
    repeat (53) @(posedge clk);
    #1 div = 16'd2;
    end_phase("div_drop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
